// File: rtl/serial_word_collector.sv
// Serial-in / parallel-out word collector: LSB-first bits on shift strobes are
// assembled into WIDTH-bit words and presented through a valid/ready handshake.
module serial_word_collector #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             shb,
  input  logic             bit_in,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic             busy,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sreg_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             busy_q;
  logic             overrun_q;

  // Control FSM with all outputs held in registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= IDLE;
      sreg_q    <= {WIDTH{1'b0}};
      cnt_q     <= {CW{1'b0}};
      data_q    <= {WIDTH{1'b0}};
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= COLLECT;
            sreg_q    <= {WIDTH{1'b0}};
            cnt_q     <= {CW{1'b0}};
            overrun_q <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        COLLECT: begin
          // A restart wins over a strobe on the same edge.
          if (start) begin
            sreg_q <= {WIDTH{1'b0}};
            cnt_q  <= {CW{1'b0}};
          end else if (shb) begin
            sreg_q <= {bit_in, sreg_q[WIDTH-1:1]};
            if (cnt_q == LAST_CNT) begin
              data_q  <= {bit_in, sreg_q[WIDTH-1:1]};
              valid_q <= 1'b1;
              cnt_q   <= {CW{1'b0}};
              busy_q  <= 1'b0;
              state_q <= HOLD;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        HOLD: begin
          // A held word is never dropped: start only counts alongside out_ready.
          if (out_ready) begin
            valid_q <= 1'b0;
            if (start) begin
              state_q   <= COLLECT;
              sreg_q    <= {WIDTH{1'b0}};
              cnt_q     <= {CW{1'b0}};
              overrun_q <= 1'b0;
              busy_q    <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end else if (shb) begin
            overrun_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out  = data_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_serial_word_collector.sv
// Directed self-checking bench for serial_word_collector at WIDTH=4.
module tb_serial_word_collector;

  logic       clk = 1'b0;
  logic       clr, start, shb, bit_in, out_ready;
  logic [3:0] data_out;
  logic       out_valid, busy, overrun;
  int         tests = 0;
  int         fails = 0;

  serial_word_collector #(.WIDTH(4)) dut (
    .clk(clk), .clr(clr), .start(start), .shb(shb), .bit_in(bit_in),
    .out_ready(out_ready), .data_out(data_out), .out_valid(out_valid),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic strobe(input logic b);
    shb = 1'b1; bit_in = b; step(); shb = 1'b0; bit_in = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1; start = 1'b0; shb = 1'b0; bit_in = 1'b0; out_ready = 1'b0;
    step(); step();
    tests++; if ({data_out, out_valid, busy, overrun} !== 7'b0) begin fails++; $display("FAIL reset_outputs: got %b expected %b", {data_out, out_valid, busy, overrun}, 7'b0); end
    clr = 1'b0; step();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_basic();
    pulse_start();
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy: got %b expected 1", busy); end
    strobe(1'b1); strobe(1'b0); strobe(1'b1);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_early_valid: got %b expected 0", out_valid); end
    strobe(1'b1);
    tests++; if (data_out !== 4'hD) begin fails++; $display("FAIL basic_data: got %h expected d", data_out); end
    tests++; if ({out_valid, busy} !== 2'b10) begin fails++; $display("FAIL basic_valid_busy: got %b expected 10", {out_valid, busy}); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    tests++; if ({out_valid, busy} !== 2'b00) begin fails++; $display("FAIL basic_accept: got %b expected 00", {out_valid, busy}); end
    tests++; if (data_out !== 4'hD) begin fails++; $display("FAIL basic_data_kept: got %h expected d", data_out); end
    // In IDLE strobes are ignored: nothing starts, no overrun.
    strobe(1'b1); step();
    tests++; if ({out_valid, busy, overrun} !== 3'b000) begin fails++; $display("FAIL idle_ignores_shb: got %b expected 000", {out_valid, busy, overrun}); end
  endtask

  task automatic test_gaps();
    logic [3:0] bits;
    bits = 4'b1101;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      strobe(bits[i]);
      if (i < 3) begin
        for (int g = 0; g < 3; g++) begin
          tests++; if ({out_valid, busy} !== 2'b01) begin fails++; $display("FAIL gaps_bit%0d_gap%0d: got valid,busy=%b expected 01", i, g, {out_valid, busy}); end
          step();
        end
      end
    end
    tests++; if ({data_out, out_valid} !== {4'hD, 1'b1}) begin fails++; $display("FAIL gaps_word: got data=%h valid=%b expected d 1", data_out, out_valid); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  task automatic test_overrun();
    pulse_start();
    strobe(1'b1); strobe(1'b0); strobe(1'b1); strobe(1'b1);
    step();
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL overrun_pre: got %b expected 0", overrun); end
    strobe(1'b0);
    tests++; if ({overrun, out_valid, data_out} !== {1'b1, 1'b1, 4'hD}) begin fails++; $display("FAIL overrun_set: got ovr=%b valid=%b data=%h expected 1 1 d", overrun, out_valid, data_out); end
    step();
    tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL overrun_sticky: got %b expected 1", overrun); end
    out_ready = 1'b1; start = 1'b1; step(); out_ready = 1'b0; start = 1'b0;
    tests++; if ({out_valid, overrun, busy} !== 3'b001) begin fails++; $display("FAIL overrun_clear: got valid,ovr,busy=%b expected 001", {out_valid, overrun, busy}); end
  endtask

  task automatic test_restart();
    pulse_start();
    strobe(1'b1); strobe(1'b1);
    // Restart with a strobe on the same edge: the strobe must be ignored.
    start = 1'b1; shb = 1'b1; bit_in = 1'b1; step();
    start = 1'b0; shb = 1'b0; bit_in = 1'b0;
    strobe(1'b0); strobe(1'b0); strobe(1'b1);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL restart_early_valid: got %b expected 0", out_valid); end
    strobe(1'b0);
    tests++; if ({data_out, out_valid} !== {4'h4, 1'b1}) begin fails++; $display("FAIL restart_word: got data=%h valid=%b expected 4 1", data_out, out_valid); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    pulse_start();
    strobe(1'b1); strobe(1'b1); strobe(1'b1);
    #2 clr = 1'b1;
    #1;
    tests++; if ({data_out, out_valid, busy, overrun} !== 7'b0) begin fails++; $display("FAIL async_clr: got %b expected %b", {data_out, out_valid, busy, overrun}, 7'b0); end
    step(); clr = 1'b0;
    for (int i = 0; i < 4; i++) strobe(1'b1);
    step();
    tests++; if ({data_out, out_valid, busy, overrun} !== 7'b0) begin fails++; $display("FAIL post_clr_shb: got %b expected %b", {data_out, out_valid, busy, overrun}, 7'b0); end
  endtask

  task automatic test_back_to_back();
    pulse_start();
    strobe(1'b1); strobe(1'b0); strobe(1'b1); strobe(1'b1);
    // start without out_ready leaves the word held.
    start = 1'b1; step(); start = 1'b0;
    tests++; if ({data_out, out_valid, busy} !== {4'hD, 1'b1, 1'b0}) begin fails++; $display("FAIL hold_start_ignored: got data=%h valid=%b busy=%b expected d 1 0", data_out, out_valid, busy); end
    out_ready = 1'b1; start = 1'b1; shb = 1'b1; bit_in = 1'b0; step();
    out_ready = 1'b0; start = 1'b0; shb = 1'b0;
    tests++; if ({out_valid, busy, overrun} !== 3'b010) begin fails++; $display("FAIL b2b_accept: got valid,busy,ovr=%b expected 010", {out_valid, busy, overrun}); end
    strobe(1'b1); strobe(1'b1); strobe(1'b1);
    tests++; if ({out_valid, data_out} !== {1'b0, 4'hD}) begin fails++; $display("FAIL b2b_partial: got valid=%b data=%h expected 0 d", out_valid, data_out); end
    strobe(1'b1);
    tests++; if ({data_out, out_valid, overrun} !== {4'hF, 1'b1, 1'b0}) begin fails++; $display("FAIL b2b_word2: got data=%h valid=%b ovr=%b expected f 1 0", data_out, out_valid, overrun); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_overrun();
    test_restart();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_word_collector.md
Name: serial_word_collector

Overview:
- Serial-in / parallel-out receiver for the sequential multiplier datapath.
- Accepts one bit per enabled clock, LSB first, on the same shift-strobe convention the datapath uses.
- Assembles WIDTH bits into a word and presents it with a valid/ready handshake.
- Flags overrun if bits keep arriving while a completed word is still unaccepted.

Parameters:
- WIDTH, 4, word length in bits; must be >= 2.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- clr  input  1  reset, asynchronous, active-high.
- start  input  1  begin or restart collection of a new word.
- shb  input  1  shift strobe; bit_in is sampled on a clk edge only when shb=1.
- bit_in  input  1  serial data, LSB first.
- out_ready  input  1  consumer accepts data_out when out_valid=1.
- data_out  output  WIDTH  assembled word; stable while out_valid=1.
- out_valid  output  1  completed word available.
- busy  output  1  high in COLLECT state.
- overrun  output  1  sticky: a bit was strobed while a word was held.

Behaviour:
- Reset (clr=1, any time, asynchronous): state=IDLE; data_out=0, out_valid=0, busy=0, overrun=0; internal shift register and bit counter = 0.
  - A reset mid-word discards all partial data.
- Internal state:
  - Shift register sreg[WIDTH-1:0].
  - Bit counter cnt, width clog2(WIDTH)+1.
  - FSM states IDLE, COLLECT, HOLD.
- IDLE:
  - shb is ignored.
  - start=1 → COLLECT; sreg=0, cnt=0, overrun=0.
- COLLECT (busy=1):
  - On a clk edge with shb=1: sreg <= {bit_in, sreg[WIDTH-1:1]}, cnt <= cnt+1.
  - The first received bit therefore ends in data_out[0].
  - shb=0: no change; gaps of any length between bits are allowed.
  - When shb=1 and cnt==WIDTH-1:
    - data_out <= {bit_in, sreg[WIDTH-1:1]}, out_valid <= 1, cnt <= 0.
    - → HOLD.
    - out_valid is visible immediately after the edge that samples the WIDTH-th bit (0-cycle added latency).
  - start=1 in COLLECT restarts: sreg=0, cnt=0, and shb/bit_in on that edge are ignored. start has priority over shb.
- HOLD (busy=0, out_valid=1, data_out frozen):
  - out_ready=1 → out_valid <= 0 on that edge. Next state is IDLE, or COLLECT if start=1 on the same edge.
    - Back-to-back words are supported.
    - shb on that same edge is ignored.
  - shb=1 with out_ready=0 → overrun <= 1; the bit is discarded; data_out is unchanged.
  - start=1 with out_ready=0 → remains in HOLD and start is ignored (a held word is never dropped).
- overrun is cleared only by clr or by start being accepted (IDLE→COLLECT or HOLD→COLLECT).
- data_out keeps its last word after acceptance until the next word completes; consumers qualify it with out_valid.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- WIDTH=4; start pulse, then shb=1 for 4 consecutive cycles with bit_in=1,0,1,1 → after 4th edge data_out=4'hD, out_valid=1, busy=0; out_ready=1 for one cycle → out_valid=0, state IDLE.
- Same bits with shb low for 3 cycles between each bit → data_out=4'hD only after the 4th strobed edge; busy=1 throughout; out_valid=0 until then.
- Word 4'hD held with out_ready=0, then one shb pulse with bit_in=0 → overrun=1, data_out stays 4'hD; subsequent out_ready+start → out_valid=0, overrun=0, busy=1.
- Restart: 2 bits (1,1) strobed, then start, then bits 0,0,1,0 → data_out=4'h4 (partial bits discarded).
- Reset mid-word: 3 bits strobed, clr asserted asynchronously between edges → all outputs 0 immediately; shb pulses with no start afterward → outputs remain 0, busy=0.
- Back-to-back: in HOLD assert out_ready=1 and start=1 on same edge, then strobe 1,1,1,1 → first word accepted, second word 4'hF presented with out_valid=1 after 4 edges, overrun=0.
